reg_bank_fwd: RTL and testbench

REG_BANK_FWD -- requirements
Module: reg_bank_fwd

---
 rtl/rb_pkg.sv | 21 ++
 rtl/rb_regfile.sv | 57 +++++
 rtl/reg_bank_fwd.sv | 86 ++++++++
 tb/tb_reg_bank_fwd.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared defaults and forwarding-select encodings for the operand register bank.
package rb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREG_DEF   = 32;

  // One address bit minimum so a single-register bank still has a legal port.
  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int AW_DEF = addr_w(NREG_DEF);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_DM = 2'b10,
    FWD_WB = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/rb_regfile.sv
// Register storage with one write port and two write-through read ports.
// Define RB_ZERO_REG_EN to hardwire register 0 to zero.
module rb_regfile
  import rb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  localparam int AW    = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra_a,
  input  logic [AW-1:0]     ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

`ifdef RB_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [AW:0] NREG_L = NREG[AW:0];

  logic [DATA_W-1:0] mem [NREG];
  logic              wr_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_L) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_ok = we && addr_ok(wa);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  // Out-of-range and hardwired-zero addresses read 0 ahead of write-through.
  always_comb begin
    rd_a = '0;
    if (addr_ok(ra_a)) rd_a = (wr_ok && (wa == ra_a)) ? wd : mem[ra_a];
  end

  always_comb begin
    rd_b = '0;
    if (addr_ok(ra_b)) rd_b = (wr_ok && (wa == ra_b)) ? wd : mem[ra_b];
  end

endmodule

// File: rtl/reg_bank_fwd.sv
// Decode-stage operand fetch: regfile read, forwarding/immediate muxes and a
// stallable, flushable output register feeding EX.
module reg_bank_fwd
  import rb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  localparam int AW    = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  input  logic [AW-1:0]     rs_a,
  input  logic [AW-1:0]     rs_b,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic [1:0]        mux_sel_A,
  input  logic [1:0]        mux_sel_B,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic              we_wb,
  input  logic [AW-1:0]     RW_wb,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              out_valid
);

  logic [DATA_W-1:0] rf_a_p0, rf_b_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic [DATA_W-1:0] a_p1, b_p1;
  logic              vld_p1;

  rb_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (we_wb),
    .wa   (RW_wb),
    .wd   (ans_wb),
    .ra_a (rs_a),
    .ra_b (rs_b),
    .rd_a (rf_a_p0),
    .rd_b (rf_b_p0)
  );

  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] ex,
    input logic [DATA_W-1:0] dm,
    input logic [DATA_W-1:0] wb
  );
    case (fwd_sel_e'(sel))
      FWD_EX:  return ex;
      FWD_DM:  return dm;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

  assign a_p0 = fwd_mux(mux_sel_A, rf_a_p0, ans_ex, ans_dm, ans_wb);
  assign b_p0 = imm_sel ? imm : fwd_mux(mux_sel_B, rf_b_p0, ans_ex, ans_dm, ans_wb);

  // p0 -> p1: output stage, priority rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      a_p1   <= '0;
      b_p1   <= '0;
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      a_p1   <= a_p0;
      b_p1   <= b_p0;
      vld_p1 <= ins_valid;
    end
  end

  assign A         = a_p1;
  assign B         = b_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_reg_bank_fwd.sv
// Randomized and directed bench for reg_bank_fwd against an array-based model.
module tb_reg_bank_fwd;

  localparam int DW = 8;
  localparam int NR = 32;
  localparam int AWT = 5;

`ifdef RB_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, ins_valid, imm_sel, we_wb, stall, flush;
  logic [AWT-1:0] rs_a, rs_b, RW_wb;
  logic [DW-1:0]  imm, ans_ex, ans_dm, ans_wb;
  logic [1:0]     mux_sel_A, mux_sel_B;
  logic [DW-1:0]  A, B;
  logic           out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_reg [NR];
  logic [DW-1:0] m_a, m_b;
  logic          m_v;

  always #5 clk = ~clk;

  reg_bank_fwd #(.DATA_W(DW), .NREG(NR)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .rs_a(rs_a), .rs_b(rs_b),
    .imm(imm), .imm_sel(imm_sel), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
    .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb), .we_wb(we_wb),
    .RW_wb(RW_wb), .stall(stall), .flush(flush), .A(A), .B(B),
    .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Value an operand read sees this cycle, from the register model's rules.
  function automatic logic [DW-1:0] model_read(input logic [AWT-1:0] a);
    if (ZR && a == 0) return '0;
    if (we_wb && RW_wb == a) return ans_wb;
    return m_reg[a];
  endfunction

  function automatic logic [DW-1:0] model_pick(input logic [1:0] sel, input logic [DW-1:0] rf);
    case (sel)
      2'd1:    return ans_ex;
      2'd2:    return ans_dm;
      2'd3:    return ans_wb;
      default: return rf;
    endcase
  endfunction

  task automatic idle();
    rst = 0; ins_valid = 0; imm_sel = 0; we_wb = 0; stall = 0; flush = 0;
    rs_a = 0; rs_b = 0; RW_wb = 0; imm = 0; ans_ex = 0; ans_dm = 0; ans_wb = 0;
    mux_sel_A = 0; mux_sel_B = 0;
  endtask

  // Advance one clock, update the model, and compare all outputs.
  task automatic cycle(input string tag);
    logic [DW-1:0] na, nb;
    na = model_pick(mux_sel_A, model_read(rs_a));
    nb = imm_sel ? imm : model_pick(mux_sel_B, model_read(rs_b));
    if (rst) begin
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_a = 0; m_b = 0; m_v = 0;
    end else begin
      if (we_wb && !(ZR && RW_wb == 0)) m_reg[RW_wb] = ans_wb;
      if (flush) begin
        m_a = 0; m_b = 0; m_v = 0;
      end else if (!stall) begin
        m_a = na; m_b = nb; m_v = ins_valid;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".A"}, 32'(A), 32'(m_a));
    check({tag, ".B"}, 32'(B), 32'(m_b));
    check({tag, ".vld"}, 32'(out_valid), 32'(m_v));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_a = 0; m_b = 0; m_v = 0;
    idle();
    @(negedge clk);

    rst = 1; cycle("reset");
    idle(); rs_a = 3; rs_b = 4; ins_valid = 1; cycle("rd_after_rst");
    check("rd_after_rst.A_const", 32'(A), 32'h00);
    check("rd_after_rst.v_const", 32'(out_valid), 32'h1);

    idle(); we_wb = 1; RW_wb = 7; ans_wb = 8'hE0; cycle("wr7");
    idle(); rs_a = 7; ins_valid = 1; cycle("rd7");
    check("rd7.A_const", 32'(A), 32'hE0);

    idle(); we_wb = 1; RW_wb = 5; ans_wb = 8'h5A; rs_b = 5; ins_valid = 1; cycle("wthru");
    check("wthru.B_const", 32'(B), 32'h5A);

    idle(); ans_ex = 8'hC0; ans_dm = 8'hD0; imm = 8'hFF; ans_wb = 8'h3C;
    mux_sel_A = 2'b11; imm_sel = 1; ins_valid = 1; cycle("fwd_wb_imm");
    check("fwd_wb_imm.A_const", 32'(A), 32'h3C);
    check("fwd_wb_imm.B_const", 32'(B), 32'hFF);
    imm_sel = 0; mux_sel_B = 2'b01; cycle("fwd_ex");
    check("fwd_ex.B_const", 32'(B), 32'hC0);
    mux_sel_B = 2'b10; cycle("fwd_dm");
    check("fwd_dm.B_const", 32'(B), 32'hD0);

    idle(); ans_ex = 8'h11; mux_sel_A = 2'b01; ins_valid = 1; cycle("ld11");
    ans_ex = 8'h22; stall = 1; cycle("stall1"); cycle("stall2");
    check("stall.A_const", 32'(A), 32'h11);
    flush = 1; cycle("stall_flush");
    check("flush.A_const", 32'(A), 32'h00);
    check("flush.v_const", 32'(out_valid), 32'h0);

    idle(); we_wb = 1; RW_wb = 0; ans_wb = 8'hAA; cycle("wr0");
    idle(); rs_a = 0; ins_valid = 1; cycle("rd0");
    check("zero_reg.A_const", 32'(A), ZR ? 32'h00 : 32'hAA);

    idle(); ans_ex = 8'h77; mux_sel_A = 2'b01; ins_valid = 1; cycle("ld77");
    stall = 1; rst = 1; we_wb = 1; RW_wb = 9; ans_wb = 8'h99; cycle("rst_in_stall");
    idle(); rs_a = 9; ins_valid = 1; cycle("rd9_after_rst");
    check("rst_drops_write.A_const", 32'(A), 32'h00);

    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(31) == 0);
      flush     = ($urandom_range(7) == 0);
      stall     = ($urandom_range(3) == 0);
      ins_valid = 1'($urandom);
      imm_sel   = ($urandom_range(3) == 0);
      we_wb     = 1'($urandom);
      rs_a      = AWT'($urandom);
      rs_b      = ($urandom_range(3) == 0) ? RW_wb : AWT'($urandom);
      RW_wb     = ($urandom_range(3) == 0) ? rs_a : AWT'($urandom);
      mux_sel_A = 2'($urandom);
      mux_sel_B = 2'($urandom);
      imm       = DW'($urandom);
      ans_ex    = DW'($urandom);
      ans_dm    = DW'($urandom);
      ans_wb    = DW'($urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
